// File: rtl/baud_tick_gen.sv
// Run-time programmable bit-period tick generator with mid-period strobe (BAUD_TICK_HALF_EN builds half_tick_o).
// All outputs registered; tick k lands exactly k*div cycles after the accepted start; no backpressure.
module baud_tick_gen #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 434,
  parameter int unsigned CNT_WIDTH   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 periodic_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [CNT_WIDTH-1:0] n_ticks_i,
  output logic                 tick_o,
  output logic                 half_tick_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] tick_idx_o
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] n_q, n_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic                 periodic_q, periodic_d;
  logic                 tick_q, tick_d;
  logic                 done_q, done_d;

  logic                 start_acc;
  logic                 run_cont;
  logic                 wrap;
  logic [DIV_WIDTH-1:0] eff_div;
  logic [DIV_WIDTH-1:0] base_cnt;
  logic [DIV_WIDTH-1:0] sel_div;
  logic [DIV_WIDTH-1:0] cnt_inc;
  logic [CNT_WIDTH-1:0] base_idx;
  logic [CNT_WIDTH-1:0] idx_inc;
  logic [CNT_WIDTH-1:0] sel_n;
  logic                 sel_periodic;

  // cnt_q is the position within the period of the current cycle, with the
  // start cycle itself at position 0; a start therefore evaluates from a
  // zero base and the freshly selected settings in the same cycle.
  always_comb begin
    eff_div      = (div_i == '0) ? DIV_WIDTH'(DEFAULT_DIV) : div_i;
    start_acc    = start_i && !abort_i && ((state_q == IDLE) || done_q);
    run_cont     = (state_q == RUN) && !done_q && !abort_i;
    base_cnt     = start_acc ? '0 : cnt_q;
    base_idx     = start_acc ? '0 : idx_q;
    sel_div      = start_acc ? eff_div : div_q;
    sel_n        = start_acc ? n_ticks_i : n_q;
    sel_periodic = start_acc ? periodic_i : periodic_q;
    wrap         = (base_cnt == sel_div - DIV_WIDTH'(1));
    cnt_inc      = base_cnt + DIV_WIDTH'(1);
    idx_inc      = base_idx + CNT_WIDTH'(1);

    state_d    = IDLE;
    div_d      = div_q;
    n_d        = n_q;
    periodic_d = periodic_q;
    cnt_d      = '0;
    idx_d      = idx_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;

    if (start_acc) begin
      div_d      = eff_div;
      n_d        = n_ticks_i;
      periodic_d = periodic_i;
    end

    if (start_acc || run_cont) begin
      state_d = RUN;
      cnt_d   = wrap ? '0 : cnt_inc;
      idx_d   = wrap ? idx_inc : base_idx;
      tick_d  = wrap;
      // n_q == 0 encodes 2^CNT_WIDTH ticks, matched by idx_inc wrapping to 0
      done_d  = wrap && !sel_periodic && (idx_inc == sel_n);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      div_q      <= DIV_WIDTH'(DEFAULT_DIV);
      cnt_q      <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      periodic_q <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      periodic_q <= periodic_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
    end
  end

`ifdef BAUD_TICK_HALF_EN
  logic half_q, half_d;

  // floor(div/2) is nonzero only for div >= 2, so the !wrap term suppresses div == 1
  always_comb begin
    half_d = (start_acc || run_cont) && !wrap && (cnt_inc == (sel_div >> 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      half_q <= 1'b0;
    end else begin
      half_q <= half_d;
    end
  end

  assign half_tick_o = half_q;
`else
  assign half_tick_o = 1'b0;
`endif

  assign tick_o     = tick_q;
  assign done_o     = done_q;
  assign busy_o     = (state_q == RUN);
  assign tick_idx_o = idx_q;

endmodule
